// File: rtl/dcache_ctrl_pkg.sv
// Shared constants for the direct-mapped write-through data cache:
// FSM encoding, default geometry and address field positions.
package dcache_ctrl_pkg;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FILL0 = 2'd1;
  localparam logic [1:0] S_FILL1 = 2'd2;
  localparam logic [1:0] S_WRITE = 2'd3;

  localparam int unsigned BASE_ADDR_DEF  = 1024;
  localparam int          INDEX_BITS_DEF = 6;
  localparam int          DATA_W_DEF     = 32;

  // Field positions within the word offset (byte offset >> 2).
  localparam int WORD_POS  = 0;
  localparam int INDEX_POS = 1;

  function automatic int tag_bits(input int data_w, input int index_bits);
    return data_w - 2 - INDEX_POS - index_bits;
  endfunction

  localparam int TAG_BITS = tag_bits(DATA_W_DEF, INDEX_BITS_DEF);
  localparam int SETS     = 1 << INDEX_BITS_DEF;

endpackage

// File: rtl/dcache_array.sv
// Valid/tag/two-word line storage: combinational read, synchronous line fill
// or single-word update, synchronous clear of all valid bits.
module dcache_array
  import dcache_ctrl_pkg::*;
#(
  parameter int INDEX_BITS = INDEX_BITS_DEF,
  parameter int TAG_W      = TAG_BITS,
  parameter int DATA_W     = DATA_W_DEF
) (
  input  logic                  clk,
  input  logic                  clr,
  input  logic [INDEX_BITS-1:0] index,
  output logic                  rd_valid,
  output logic [TAG_W-1:0]      rd_tag,
  output logic [DATA_W-1:0]     rd_word0,
  output logic [DATA_W-1:0]     rd_word1,
  input  logic                  fill_en,
  input  logic [TAG_W-1:0]      fill_tag,
  input  logic [DATA_W-1:0]     fill_word0,
  input  logic [DATA_W-1:0]     fill_word1,
  input  logic                  upd_en,
  input  logic                  upd_word,
  input  logic [DATA_W-1:0]     upd_data
);

  localparam int NSETS = 1 << INDEX_BITS;

  logic [NSETS-1:0]  valid;
  logic [TAG_W-1:0]  tags  [NSETS];
  logic [DATA_W-1:0] word0 [NSETS];
  logic [DATA_W-1:0] word1 [NSETS];

  assign rd_valid = valid[index];
  assign rd_tag   = tags[index];
  assign rd_word0 = word0[index];
  assign rd_word1 = word1[index];

  always_ff @(posedge clk) begin
    if (clr) valid <= '0;
    else if (fill_en) valid[index] <= 1'b1;
  end

  // Tag and data are never cleared; only the valid bits matter after reset.
  always_ff @(posedge clk) begin
    if (fill_en) begin
      tags[index]  <= fill_tag;
      word0[index] <= fill_word0;
      word1[index] <= fill_word1;
    end else if (upd_en) begin
      if (upd_word) word1[index] <= upd_data;
      else          word0[index] <= upd_data;
    end
  end

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped write-through, no-write-allocate data cache controller.
// Read hits return same cycle; misses and writes stall for memory transactions.
module dcache_ctrl
  import dcache_ctrl_pkg::*;
#(
  parameter int unsigned BASE_ADDR  = BASE_ADDR_DEF,
  parameter int          INDEX_BITS = INDEX_BITS_DEF,
  parameter int          DATA_W     = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [DATA_W-1:0] address,
  input  logic [DATA_W-1:0] write_data,
  output logic [DATA_W-1:0] read_data,
  output logic              stall,
  output logic              m_read,
  output logic              m_write,
  output logic [DATA_W-1:0] m_address,
  output logic [DATA_W-1:0] m_write_data,
  input  logic [DATA_W-1:0] m_read_data,
  input  logic              m_ready
);

  localparam int TB = tag_bits(DATA_W, INDEX_BITS);
  localparam logic [DATA_W-1:0] BASE = DATA_W'(BASE_ADDR);

  logic [1:0]            state;
  logic [DATA_W-3:0]     off_w;
  logic                  word_sel;
  logic [INDEX_BITS-1:0] index;
  logic [TB-1:0]         tag;
  logic [DATA_W-1:0]     line_addr;
  logic [DATA_W-1:0]     fill_w0;
  logic                  rd_valid;
  logic [TB-1:0]         rd_tag;
  logic [DATA_W-1:0]     rd_word0, rd_word1;
  logic                  hit;
  logic                  fill_en, upd_en;

  // Word offset from BASE, with the borrow out of the ignored byte bits.
  assign off_w = address[DATA_W-1:2] - BASE[DATA_W-1:2]
               - {{(DATA_W-3){1'b0}}, (address[1:0] < BASE[1:0])};
  assign word_sel  = off_w[WORD_POS];
  assign index     = off_w[INDEX_POS +: INDEX_BITS];
  assign tag       = off_w[DATA_W-3 -: TB];
  assign line_addr = {off_w[DATA_W-3:1], 3'b000} + BASE;

  assign hit     = rd_valid && (rd_tag == tag);
  assign fill_en = rst && (state == S_FILL1) && m_ready;
  assign upd_en  = rst && (state == S_WRITE) && m_ready && hit;

  dcache_array #(
    .INDEX_BITS(INDEX_BITS),
    .TAG_W     (TB),
    .DATA_W    (DATA_W)
  ) u_array (
    .clk       (clk),
    .clr       (!rst),
    .index     (index),
    .rd_valid  (rd_valid),
    .rd_tag    (rd_tag),
    .rd_word0  (rd_word0),
    .rd_word1  (rd_word1),
    .fill_en   (fill_en),
    .fill_tag  (tag),
    .fill_word0(fill_w0),
    .fill_word1(m_read_data),
    .upd_en    (upd_en),
    .upd_word  (word_sel),
    .upd_data  (write_data)
  );

  always_comb begin
    stall = 1'b0;
    case (state)
      S_IDLE:  stall = mem_write || (mem_read && !hit);
      S_FILL0: stall = 1'b1;
      S_FILL1: stall = 1'b1;
      S_WRITE: stall = !m_ready;
      default: stall = 1'b0;
    endcase
  end

  // A simultaneous read+write is a write, so it never returns load data.
  always_comb begin
    read_data = '0;
    if (state == S_IDLE && mem_read && !mem_write && hit)
      read_data = word_sel ? rd_word1 : rd_word0;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= S_IDLE;
      m_read       <= 1'b0;
      m_write      <= 1'b0;
      m_address    <= '0;
      m_write_data <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (mem_write) begin
            state        <= S_WRITE;
            m_write      <= 1'b1;
            m_address    <= {address[DATA_W-1:2], 2'b00};
            m_write_data <= write_data;
          end else if (mem_read && !hit) begin
            state     <= S_FILL0;
            m_read    <= 1'b1;
            m_address <= line_addr;
          end
        end
        S_FILL0: if (m_ready) begin
          state     <= S_FILL1;
          m_address <= line_addr + DATA_W'(4);
        end
        S_FILL1: if (m_ready) begin
          state  <= S_IDLE;
          m_read <= 1'b0;
        end
        S_WRITE: if (m_ready) begin
          state   <= S_IDLE;
          m_write <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (state == S_FILL0 && m_ready) fill_w0 <= m_read_data;
  end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Directed bench for dcache_ctrl: expected memory transactions are queued when
// a request is driven and checked as the bench memory responds to them.
module tb_dcache_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_read, mem_write;
  logic [31:0] address, write_data, read_data;
  logic        stall, m_read, m_write;
  logic [31:0] m_address, m_write_data, m_read_data;
  logic        m_ready;

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] data;
  } txn_t;

  txn_t        exp_q[$];
  logic [31:0] bmem [int unsigned];
  int          ncmp = 0;
  int          nfail = 0;

  always #5 clk = ~clk;

  dcache_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .mem_read    (mem_read),
    .mem_write   (mem_write),
    .address     (address),
    .write_data  (write_data),
    .read_data   (read_data),
    .stall       (stall),
    .m_read      (m_read),
    .m_write     (m_write),
    .m_address   (m_address),
    .m_write_data(m_write_data),
    .m_read_data (m_read_data),
    .m_ready     (m_ready)
  );

  function automatic logic [31:0] bget(input logic [31:0] a);
    return bmem.exists(a) ? bmem[a] : 32'h0;
  endfunction

  task automatic chk(input string tg, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed=%h expected=%h", tg, obs, exp);
    end
  endtask

  // Drive one pipeline request from a negedge and serve the memory side until
  // stall drops. lat = idle cycles of an active m_* before m_ready pulses.
  task automatic do_access(input logic rd, input logic wr, input logic [31:0] addr,
                           input logic [31:0] wdata, input int lat, input bit miss,
                           input string tg);
    txn_t        t;
    int          cyc, exp_cyc, wcnt;
    bit          done;
    logic [31:0] line, exp_rd;
    line = {addr[31:3], 3'b000};
    if (wr) begin
      exp_q.push_back('{wr: 1'b1, addr: {addr[31:2], 2'b00}, data: wdata});
      exp_cyc = lat + 2;
    end else if (miss) begin
      exp_q.push_back('{wr: 1'b0, addr: line, data: 32'h0});
      exp_q.push_back('{wr: 1'b0, addr: line + 32'd4, data: 32'h0});
      exp_cyc = 2 * (lat + 1) + 2;
    end else begin
      exp_cyc = 1;
    end
    exp_rd = (rd && !wr) ? bget({addr[31:2], 2'b00}) : 32'h0;
    mem_read = rd; mem_write = wr; address = addr; write_data = wdata;
    wcnt = 0; cyc = 0; done = 0;
    while (!done && cyc < 200) begin
      #1;
      cyc++;
      chk({tg, "_excl"}, 32'(m_read && m_write), 32'h0);
      if (m_read || m_write) begin
        if (wcnt == lat) begin
          if (exp_q.size() == 0) begin
            chk({tg, "_spurious_txn"}, 32'(m_read || m_write), 32'h0);
          end else begin
            t = exp_q.pop_front();
            chk({tg, "_txn_wr"}, 32'(m_write), 32'(t.wr));
            chk({tg, "_txn_rd"}, 32'(m_read), 32'(!t.wr));
            chk({tg, "_txn_addr"}, m_address, t.addr);
            if (t.wr) chk({tg, "_txn_wdata"}, m_write_data, t.data);
          end
          m_read_data = bget(m_address);
          m_ready = 1'b1;
          wcnt = 0;
        end else begin
          wcnt++;
        end
      end
      #1;
      if (!stall) begin
        done = 1;
        chk({tg, "_rdata"}, read_data, exp_rd);
      end
      @(negedge clk);
      m_ready = 1'b0;
    end
    chk({tg, "_done"}, 32'(done), 32'h1);
    chk({tg, "_cycles"}, 32'(cyc), 32'(exp_cyc));
    chk({tg, "_txn_left"}, 32'(exp_q.size()), 32'h0);
    exp_q.delete();
    mem_read = 1'b0; mem_write = 1'b0;
    #2;
    chk({tg, "_idle_after"}, 32'(m_read || m_write), 32'h0);
    if (wr) bmem[{addr[31:2], 2'b00}] = wdata;
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b0; mem_read = 1'b0; mem_write = 1'b0; address = '0; write_data = '0;
    m_read_data = '0; m_ready = 1'b0;
    bmem[32'd1000] = 32'hFFFF_FF9C;
    bmem[32'd1512] = 32'h1234_ABCD;
    bmem[32'd1516] = 32'h0BAD_F00D;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_m_read", 32'(m_read), 32'h0);
    chk("rst_m_write", 32'(m_write), 32'h0);
    chk("rst_m_address", m_address, 32'h0);
    chk("rst_m_wdata", m_write_data, 32'h0);
    chk("rst_stall", 32'(stall), 32'h0);
    chk("rst_rdata", read_data, 32'h0);
    rst = 1'b1;
    @(negedge clk);

    // m_ready with no transaction in flight must be ignored.
    m_ready = 1'b1;
    @(negedge clk);
    m_ready = 1'b0;
    #1;
    chk("idle_ready_mem", 32'(m_read || m_write), 32'h0);
    chk("idle_ready_stall", 32'(stall), 32'h0);
    @(negedge clk);

    do_access(1, 0, 32'd1000, 32'h0, 0, 1, "cold_rd_1000");
    do_access(1, 0, 32'd1004, 32'h0, 0, 0, "hit_rd_1004");
    do_access(0, 1, 32'd1004, 32'h5, 3, 0, "wr_hit_1004");
    do_access(1, 0, 32'd1004, 32'h0, 0, 0, "rd_after_wr_1004");
    do_access(0, 1, 32'd2048, 32'h7, 1, 0, "wr_miss_2048");
    do_access(1, 0, 32'd2048, 32'h0, 1, 1, "rd_miss_2048");
    do_access(1, 0, 32'd1000, 32'h0, 0, 0, "hit_rd_1000");
    do_access(1, 0, 32'd1512, 32'h0, 2, 1, "conflict_1512");
    do_access(1, 0, 32'd1000, 32'h0, 0, 1, "refill_1000");
    do_access(1, 0, 32'd1004, 32'h0, 0, 0, "hit_rd_1004b");
    do_access(1, 1, 32'd1008, 32'h9, 1, 0, "rdwr_1008");

    // Reset in the middle of a fill of the 1512 line.
    mem_read = 1'b1; address = 32'd1512;
    #1;
    chk("abort_idle_stall", 32'(stall), 32'h1);
    @(negedge clk);
    #1;
    chk("abort_fill0_rd", 32'(m_read), 32'h1);
    chk("abort_fill0_addr", m_address, 32'd1512);
    m_read_data = bget(32'd1512);
    m_ready = 1'b1;
    @(negedge clk);
    m_ready = 1'b0;
    #1;
    chk("abort_fill1_rd", 32'(m_read), 32'h1);
    chk("abort_fill1_addr", m_address, 32'd1516);
    rst = 1'b0; mem_read = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("abort_m_read", 32'(m_read), 32'h0);
    chk("abort_m_write", 32'(m_write), 32'h0);
    chk("abort_m_address", m_address, 32'h0);
    chk("abort_m_wdata", m_write_data, 32'h0);
    chk("abort_stall", 32'(stall), 32'h0);
    chk("abort_rdata", read_data, 32'h0);
    @(negedge clk);

    do_access(1, 0, 32'd1512, 32'h0, 0, 1, "post_rst_1512");
    do_access(1, 0, 32'd1000, 32'h0, 1, 1, "post_rst_1000");
    do_access(1, 0, 32'd1516, 32'h0, 0, 1, "evicted_1516");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
